// File: rtl/find_sound_array.sv
// rtl/find_sound_array.sv - multi-mic direction finder: earliest mic index, gap to the runner-up, centred flag.
// Optional FIND_SOUND_AVERAGE_EN adds a 4-sample moving average of delta on delta_avg.
module find_sound_array #(
  parameter int NUM_MICS  = 4,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 8000,
  parameter int HOLDOFF   = 33333,
  parameter int MIN_DELTA = 4,
  localparam int DIR_W    = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_MICS-1:0] mic,
  output logic [DIR_W-1:0]    direction,
  output logic [CNT_W-1:0]    delta,
  output logic                centred,
  output logic                valid,
  output logic                busy,
  output logic [CNT_W-1:0]    delta_avg
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0]  WIN       = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0]  MIN_D     = CNT_W'(MIN_DELTA);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, RESOLVE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [NUM_MICS-1:0]   sync1_q, sync2_q, sync3_q;
  logic [NUM_MICS-1:0]   seen_q, seen_d;
  logic [CNT_W-1:0]      arr_q [NUM_MICS];
  logic [CNT_W-1:0]      arr_d [NUM_MICS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [DIR_W-1:0]      dir_q, dir_d;
  logic [CNT_W-1:0]      delta_q, delta_d;
  logic                  centred_q, centred_d;
  logic                  valid_q, valid_d;

  logic [NUM_MICS-1:0]   edge_w;
  logic [NUM_MICS-1:0]   new_seen;
  logic [CNT_W-1:0]      eff [NUM_MICS];
  logic [CNT_W-1:0]      min_arr, second_arr, res_delta;
  logic [DIR_W-1:0]      res_dir;

  assign edge_w = sync2_q & ~sync3_q;

  // Unseen channels resolve as if they arrived at the end of the window.
  always_comb begin
    min_arr    = '0;
    second_arr = WIN;
    res_dir    = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      eff[i] = seen_q[i] ? arr_q[i] : WIN;
    end
    min_arr = eff[0];
    for (int i = 1; i < NUM_MICS; i++) begin
      if (eff[i] < min_arr) begin
        min_arr = eff[i];
        res_dir = DIR_W'(i);
      end
    end
    for (int i = 0; i < NUM_MICS; i++) begin
      if ((DIR_W'(i) != res_dir) && (eff[i] < second_arr)) begin
        second_arr = eff[i];
      end
    end
    res_delta = second_arr - min_arr;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    seen_d    = seen_q;
    arr_d     = arr_q;
    dir_d     = dir_q;
    delta_d   = delta_q;
    centred_d = centred_q;
    valid_d   = 1'b0;
    new_seen  = seen_q | edge_w;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      hold_d  = '0;
      seen_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          seen_d = edge_w;
          for (int i = 0; i < NUM_MICS; i++) begin
            if (edge_w[i]) arr_d[i] = '0;
          end
          if (|edge_w) begin
            state_d = CAPTURE;
            cnt_d   = CNT_W'(1);
          end
        end
        CAPTURE: begin
          for (int i = 0; i < NUM_MICS; i++) begin
            if (edge_w[i] && !seen_q[i]) arr_d[i] = cnt_q;
          end
          seen_d = new_seen;
          if ((&new_seen) || (cnt_q == WIN)) state_d = RESOLVE;
          else                               cnt_d   = cnt_q + 1'b1;
        end
        RESOLVE: begin
          dir_d     = res_dir;
          delta_d   = res_delta;
          centred_d = (res_delta < MIN_D);
          valid_d   = 1'b1;
          hold_d    = '0;
          state_d   = HOLD;
        end
        default: begin
          if (hold_q == HOLD_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            seen_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      seen_q    <= '0;
      arr_q     <= '{default: '0};
      cnt_q     <= '0;
      hold_q    <= '0;
      dir_q     <= '0;
      delta_q   <= '0;
      centred_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= mic;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      seen_q    <= seen_d;
      arr_q     <= arr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      delta_q   <= delta_d;
      centred_q <= centred_d;
      valid_q   <= valid_d;
    end
  end

  assign direction = dir_q;
  assign delta     = delta_q;
  assign centred   = centred_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);

`ifdef FIND_SOUND_AVERAGE_EN
  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W+1:0] sum_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '{default: '0};
    end else if (valid_q) begin
      hist_q[0] <= delta_q;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      hist_q[3] <= hist_q[2];
    end
  end

  assign sum_w     = (CNT_W+2)'(hist_q[0]) + (CNT_W+2)'(hist_q[1])
                   + (CNT_W+2)'(hist_q[2]) + (CNT_W+2)'(hist_q[3]);
  assign delta_avg = CNT_W'(sum_w >> 2);
`else
  assign delta_avg = delta_q;
`endif

endmodule

// File: tb/tb_find_sound_array.sv
// tb/tb_find_sound_array.sv - randomized and directed checks of find_sound_array against an arrival-time model.
module tb_find_sound_array;
  localparam int NM  = 4;
  localparam int CW  = 16;
  localparam int WIN = 300;
  localparam int HO  = 400;
  localparam int MD  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NM-1:0] mic;
  logic [1:0]    direction;
  logic [CW-1:0] delta;
  logic          centred;
  logic          valid;
  logic          busy;
  logic [CW-1:0] delta_avg;

  find_sound_array #(
    .NUM_MICS(NM), .CNT_W(CW), .WINDOW(WIN), .HOLDOFF(HO), .MIN_DELTA(MD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mic(mic),
    .direction(direction), .delta(delta), .centred(centred),
    .valid(valid), .busy(busy), .delta_avg(delta_avg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0;
  int wide_cnt = 0;
  logic prev_valid = 1'b0;
  logic [1:0]    cap_dir;
  logic [CW-1:0] cap_delta;
  logic          cap_cen;
  logic [CW-1:0] cap_avg;
  int hist[$];
  int last_dir, last_delta, last_cen;

  always @(negedge clk) begin
    if (prev_valid) cap_avg = delta_avg;
    if (valid) begin
      vcnt++;
      if (prev_valid) wide_cnt++;
      cap_dir   = direction;
      cap_delta = delta;
      cap_cen   = centred;
    end
    prev_valid = valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Arrival of each mic relative to the earliest; late or absent mics count as WIN.
  function automatic void model(input int off[NM], output int d, output int dl, output int c);
    int mn;
    int sec;
    int arr[NM];
    mn = 1 << 30;
    for (int i = 0; i < NM; i++) if (off[i] >= 0 && off[i] < mn) mn = off[i];
    for (int i = 0; i < NM; i++)
      arr[i] = (off[i] < 0) ? WIN : ((off[i] - mn > WIN) ? WIN : off[i] - mn);
    d = 0;
    for (int i = 1; i < NM; i++) if (arr[i] < arr[d]) d = i;
    sec = WIN;
    for (int i = 0; i < NM; i++) if (i != d && arr[i] < sec) sec = arr[i];
    dl = sec - arr[d];
    c = (dl < MD) ? 1 : 0;
  endfunction

  function automatic int avg_model(input int dl);
    int s;
    hist.push_front(dl);
    if (hist.size() > 4) void'(hist.pop_back());
    s = 0;
    foreach (hist[i]) s += hist[i];
`ifdef FIND_SOUND_AVERAGE_EN
    return s >> 2;
`else
    return dl;
`endif
  endfunction

  task automatic drive_offsets(input int off[NM]);
    int mx;
    mx = 0;
    for (int i = 0; i < NM; i++) if (off[i] > mx) mx = off[i];
    for (int t = 0; t <= mx; t++) begin
      for (int i = 0; i < NM; i++) if (off[i] == t) mic[i] = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_event(input int off[NM], input string tag);
    int d, dl, c, av, sv, k;
    model(off, d, dl, c);
    av = avg_model(dl);
    sv = vcnt;
    drive_offsets(off);
    k = 0;
    while (vcnt == sv && k < WIN + 60) begin
      tick();
      k++;
    end
    check_eq({tag, "_valid_seen"}, (vcnt != sv), 1);
    tick();
    tick();
    check_eq({tag, "_dir"}, cap_dir, d);
    check_eq({tag, "_delta"}, cap_delta, dl);
    check_eq({tag, "_centred"}, cap_cen, c);
    check_eq({tag, "_avg"}, cap_avg, av);
    check_eq({tag, "_busy_hold"}, busy, 1);
    k = 0;
    while (busy && k < HO + 20) begin
      tick();
      k++;
    end
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_one_valid"}, vcnt - sv, 1);
    last_dir = d;
    last_delta = dl;
    last_cen = c;
    @(posedge clk);
    #1;
    mic = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int off[NM];
    int sv, k;
    reset = 1'b1;
    enable = 1'b0;
    mic = '0;
    repeat (3) @(posedge clk);
    tick();
    check_eq("rst_dir", direction, 0);
    check_eq("rst_delta", delta, 0);
    check_eq("rst_centred", centred, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_avg", delta_avg, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    off = '{100, 0, 200, 300};
    expect_event(off, "staggered");
    off = '{0, -1, 0, -1};
    expect_event(off, "tie");
    off = '{-1, -1, -1, 0};
    expect_event(off, "single");

    // Mic0 toggles through the holdoff; only a rise after holdoff may start a capture.
    sv = vcnt;
    off = '{-1, 0, -1, -1};
    drive_offsets(off);
    k = 0;
    while (vcnt == sv && k < WIN + 60) begin
      tick();
      k++;
    end
    check_eq("ho_first_valid", vcnt - sv, 1);
    k = 0;
    while (busy && k < HO + 20) begin
      if (k % 50 == 10) mic[0] = ~mic[0];
      tick();
      k++;
    end
    check_eq("ho_no_valid", vcnt - sv, 1);
    check_eq("ho_busy_end", busy, 0);
    mic = '0;
    repeat (5) @(posedge clk);
    #1;
    void'(avg_model(WIN));
    off = '{0, -1, -1, -1};
    expect_event(off, "after_ho");

    // Enable drop mid-capture discards the capture and holds outputs.
    sv = vcnt;
    mic[2] = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (10) tick();
    check_eq("en_busy", busy, 0);
    check_eq("en_no_valid", vcnt - sv, 0);
    check_eq("en_dir_hold", direction, last_dir);
    check_eq("en_delta_hold", delta, last_delta);
    check_eq("en_cen_hold", centred, last_cen);
    @(posedge clk);
    #1;
    enable = 1'b1;
    off = '{0, 2, -1, -1};
    expect_event(off, "reenable");

    // Asynchronous reset mid-capture.
    sv = vcnt;
    mic[1] = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_dir", direction, 0);
    check_eq("arst_delta", delta, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_avg", delta_avg, 0);
    mic = '0;
    hist.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (WIN + 20) tick();
    check_eq("arst_no_valid", vcnt - sv, 0);

    for (int n = 1; n <= 4; n++) begin
      off = '{0, 100 * n, -1, -1};
      expect_event(off, "avg_seq");
    end

    for (int n = 0; n < 14; n++) begin
      int spread;
      spread = ($urandom_range(0, 2) == 0) ? 5 : WIN + 20;
      for (int i = 0; i < NM; i++)
        off[i] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, spread));
      off[$urandom_range(0, NM - 1)] = int'($urandom_range(0, 3));
      expect_event(off, "rand");
    end

    check_eq("valid_width", wide_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
